// File: rtl/qam_sym_packer.sv
// ============================================================================
//  qam_sym_packer : byte FIFO + preamble insertion + nibble splitter feeding
//                   the 16-QAM modulator symbol handshake.
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module qam_sym_packer #(
   parameter int          FIFO_DEPTH = 16,
   parameter int          PRE_LEN    = 8,
   parameter logic [31:0] PRE_WORD   = 32'h3C3C_3C3C
) (
   input  logic        axi_clk,
   input  logic        axi_rst,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   output logic        s_ready,
   output logic        sym_valid,
   output logic [3:0]  sym_data,
   input  logic        sym_ready,
   output logic        sym_last,
   output logic        underrun,
   output logic [15:0] frame_cnt
);

   localparam int              C_AW       = $clog2(FIFO_DEPTH);
   localparam logic [C_AW:0]   C_FULL     = (C_AW + 1)'(FIFO_DEPTH);
   localparam logic [2:0]      C_PRE_LAST = 3'(PRE_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_HI   = 2'd2,
      ST_LO   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        pre_cnt_q, pre_cnt_d;
   logic [C_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [C_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [C_AW:0]     count_q, count_d;
   logic              underrun_q, underrun_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [8:0]        mem_q [FIFO_DEPTH];

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [8:0]        w_head;
   logic [31:0]       w_pre_shift;

   // FIFO status and push side; s_ready is held low for the whole reset cycle
   always_comb begin
      w_full      = (count_q == C_FULL);
      w_empty     = (count_q == '0);
      s_ready     = !w_full && !axi_rst;
      w_push      = s_valid && s_ready;
      w_head      = mem_q[rd_ptr_q];
      w_pre_shift = PRE_WORD << {pre_cnt_q, 2'b00};
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_push) begin
         wr_ptr_d = wr_ptr_q + C_AW'(1);
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + C_AW'(1);
      end
      if (w_push && !w_pop) begin
         count_d = count_q + (C_AW + 1)'(1);
      end else if (w_pop && !w_push) begin
         count_d = count_q - (C_AW + 1)'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      pre_cnt_d   = pre_cnt_q;
      underrun_d  = underrun_q;
      frame_cnt_d = frame_cnt_q;
      sym_valid   = 1'b0;
      sym_data    = 4'h0;
      sym_last    = 1'b0;
      w_pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!w_empty) begin
               state_d   = ST_PRE;
               pre_cnt_d = 3'd0;
            end
         end
         ST_PRE: begin
            sym_valid = 1'b1;
            sym_data  = w_pre_shift[31:28];
            if (sym_ready) begin
               if (pre_cnt_q == C_PRE_LAST) begin
                  state_d = ST_HI;
               end else begin
                  pre_cnt_d = pre_cnt_q + 3'd1;
               end
            end
         end
         ST_HI: begin
            // An empty FIFO here means the source starved us inside a frame
            sym_valid = !w_empty;
            sym_data  = w_head[7:4];
            if (w_empty) begin
               underrun_d = 1'b1;
            end else if (sym_ready) begin
               state_d = ST_LO;
            end
         end
         ST_LO: begin
            sym_valid = 1'b1;
            sym_data  = w_head[3:0];
            sym_last  = w_head[8];
            if (sym_ready) begin
               w_pop = 1'b1;
               if (w_head[8]) begin
                  state_d     = ST_IDLE;
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  state_d = ST_HI;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge axi_clk) begin
      if (axi_rst) begin
         state_q     <= ST_IDLE;
         pre_cnt_q   <= 3'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         underrun_q  <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         pre_cnt_q   <= pre_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         underrun_q  <= underrun_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by count_q alone
   always_ff @(posedge axi_clk) begin
      if (w_push) begin
         mem_q[wr_ptr_q] <= {s_last, s_data};
      end
   end

   assign underrun  = underrun_q;
   assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_qam_sym_packer.sv
// ============================================================================
//  tb_qam_sym_packer : directed self-checking bench for qam_sym_packer.
//  Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_qam_sym_packer;

   logic        axi_clk   = 1'b0;
   logic        axi_rst   = 1'b1;
   logic        s_valid   = 1'b0;
   logic [7:0]  s_data    = 8'h00;
   logic        s_last    = 1'b0;
   logic        sym_ready = 1'b0;
   logic        s_ready;
   logic        sym_valid;
   logic [3:0]  sym_data;
   logic        sym_last;
   logic        underrun;
   logic [15:0] frame_cnt;

   int          n_chk = 0;
   int          n_bad = 0;
   int          cyc   = 0;
   bit          rnd_en = 1'b0;
   logic        prev_stall = 1'b0;
   logic [4:0]  prev_sym   = 5'h0;
   logic [4:0]  got_q [$];
   logic [4:0]  exp_q [$];
   int          got_cyc [$];

   qam_sym_packer #(
      .FIFO_DEPTH (16),
      .PRE_LEN    (8),
      .PRE_WORD   (32'h3C3C_3C3C)
   ) u_dut (
      .axi_clk   (axi_clk),
      .axi_rst   (axi_rst),
      .s_valid   (s_valid),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_ready   (s_ready),
      .sym_valid (sym_valid),
      .sym_data  (sym_data),
      .sym_ready (sym_ready),
      .sym_last  (sym_last),
      .underrun  (underrun),
      .frame_cnt (frame_cnt)
   );

   always #5 axi_clk = ~axi_clk;

   always @(posedge axi_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Symbol monitor: records handshakes and checks that stalled symbols hold
   always @(negedge axi_clk) begin
      if (axi_rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 32'(sym_valid), 32'd1);
            chk("hold_sym", 32'({sym_last, sym_data}), 32'(prev_sym));
         end
         if (sym_valid && sym_ready) begin
            got_q.push_back({sym_last, sym_data});
            got_cyc.push_back(cyc);
         end
         prev_stall = sym_valid && !sym_ready;
         prev_sym   = {sym_last, sym_data};
      end
   end

   initial begin
      forever begin
         @(posedge axi_clk);
         #1;
         if (rnd_en) sym_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   // Called at posedge+1; returns at posedge+1 just after the accepting edge
   task automatic send(input logic [7:0] d, input logic l);
      bit ok;
      int k;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      k = 0;
      do begin
         @(negedge axi_clk);
         ok = s_ready;
         @(posedge axi_clk);
         #1;
         k++;
      end while (!ok && k < 300);
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (!ok) chk("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_frames(input logic [15:0] target);
      int k = 0;
      while (frame_cnt !== target && k < 600) begin
         @(posedge axi_clk);
         #1;
         k++;
      end
      if (k >= 600) chk("frame_timeout", 32'(frame_cnt), 32'(target));
   endtask

   task automatic wait_syms(input int n);
      int k = 0;
      while (got_q.size() < n && k < 600) begin
         @(posedge axi_clk);
         #1;
         k++;
      end
      if (k >= 600) chk("sym_timeout", got_q.size(), n);
   endtask

   task automatic push_pre();
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, ((k % 2) == 1) ? 4'hC : 4'h3});
   endtask

   task automatic push_byte(input logic [7:0] b, input logic l);
      exp_q.push_back({1'b0, b[7:4]});
      exp_q.push_back({l, b[3:0]});
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
      end
   endtask

   task automatic clear_q();
      got_q.delete();
      got_cyc.delete();
      exp_q.delete();
   endtask

   initial begin
      logic [3:0] t1_d [10];
      int acc;
      int last_acc;
      t1_d = '{4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC, 4'h3, 4'hC, 4'hA, 4'h5};

      // Reset state
      repeat (3) @(posedge axi_clk);
      #1;
      @(negedge axi_clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_valid", 32'(sym_valid), 32'd0);
      chk("rst_last", 32'(sym_last), 32'd0);
      chk("rst_data", 32'(sym_data), 32'd0);
      chk("rst_underrun", 32'(underrun), 32'd0);
      chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;

      // Single byte frame, cycle-exact latency and back-to-back symbols
      clear_q();
      sym_ready = 1'b1;
      send(8'hA5, 1'b1);
      @(negedge axi_clk);
      chk("t1_idle_after_accept", 32'(sym_valid), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge axi_clk);
         chk("t1_valid", 32'(sym_valid), 32'd1);
         chk("t1_data", 32'(sym_data), 32'(t1_d[i]));
         chk("t1_last", 32'(sym_last), (i == 9) ? 32'd1 : 32'd0);
      end
      @(negedge axi_clk);
      chk("t1_done_valid", 32'(sym_valid), 32'd0);
      chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      @(posedge axi_clk);
      #1;

      // Two-byte frame under random back-pressure
      clear_q();
      rnd_en = 1'b1;
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      wait_frames(16'd2);
      rnd_en    = 1'b0;
      sym_ready = 1'b1;
      push_pre();
      push_byte(8'h12, 1'b0);
      push_byte(8'h34, 1'b1);
      cmp_q("t2_seq");
      chk("t2_underrun", 32'(underrun), 32'd0);

      // FIFO fill with the modulator stalled
      sym_ready = 1'b0;
      s_valid   = 1'b1;
      s_last    = 1'b0;
      acc       = 0;
      last_acc  = -1;
      for (int i = 0; i < 20; i++) begin
         s_data = 8'(i);
         @(negedge axi_clk);
         if (s_ready) begin
            acc++;
            last_acc = i;
         end
         @(posedge axi_clk);
         #1;
      end
      s_valid = 1'b0;
      @(negedge axi_clk);
      chk("t3_accepted", acc, 16);
      chk("t3_last_accept_idx", last_acc, 15);
      chk("t3_s_ready_full", 32'(s_ready), 32'd0);
      chk("t3_stalled_valid", 32'(sym_valid), 32'd1);
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b1;
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;
      @(negedge axi_clk);
      chk("t3_flush_s_ready", 32'(s_ready), 32'd1);
      chk("t3_flush_valid", 32'(sym_valid), 32'd0);
      chk("t3_flush_frame_cnt", 32'(frame_cnt), 32'd0);
      @(posedge axi_clk);
      #1;

      // Mid-frame starvation
      clear_q();
      sym_ready = 1'b1;
      send(8'h12, 1'b0);
      wait_syms(10);
      for (int i = 0; i < 10; i++) begin
         @(negedge axi_clk);
         chk("t4_gap_valid", 32'(sym_valid), 32'd0);
      end
      @(posedge axi_clk);
      #1;
      send(8'h34, 1'b1);
      wait_frames(16'd1);
      push_pre();
      push_byte(8'h12, 1'b0);
      push_byte(8'h34, 1'b1);
      cmp_q("t4_seq");
      chk("t4_underrun", 32'(underrun), 32'd1);

      // Back-to-back single-byte frames; counter continues from 1
      clear_q();
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      wait_frames(16'd3);
      push_pre();
      push_byte(8'h01, 1'b1);
      push_pre();
      push_byte(8'h02, 1'b1);
      cmp_q("t5_seq");
      if (got_cyc.size() >= 11) chk("t5_idle_gap", got_cyc[10] - got_cyc[9], 2);
      chk("t5_frame_cnt", 32'(frame_cnt), 32'd3);

      // Reset during the third preamble symbol
      clear_q();
      send(8'h55, 1'b1);
      wait_syms(2);
      chk("t6_pre3_data", 32'(sym_data), 32'h3);
      axi_rst = 1'b1;
      @(posedge axi_clk);
      #1;
      axi_rst = 1'b0;
      @(negedge axi_clk);
      chk("t6_valid", 32'(sym_valid), 32'd0);
      chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
      chk("t6_underrun", 32'(underrun), 32'd0);
      chk("t6_s_ready", 32'(s_ready), 32'd1);
      repeat (3) begin
         @(negedge axi_clk);
         chk("t6_stays_idle", 32'(sym_valid), 32'd0);
      end
      @(posedge axi_clk);
      #1;
      clear_q();
      send(8'h55, 1'b1);
      wait_frames(16'd1);
      push_pre();
      push_byte(8'h55, 1'b1);
      cmp_q("t6_resend");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
